// File: rtl/spi_prog_loader_pkg.sv
// Shared types and constants for the SPI program loader.
// Holds the FSM state encoding, opcodes, memory map and the write-window check.
package spi_prog_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADDR  = 2'd1,
        DATA  = 2'd2,
        WRITE = 2'd3
    } prog_state_t;

    localparam logic [7:0]  CMD_ADDR   = 8'h01;
    localparam logic [7:0]  CMD_DATA   = 8'h02;

    localparam logic [31:0] IMEM_BASE  = 32'h1000_0000;
    localparam logic [31:0] DMEM_BASE  = 32'h1000_4000;
    localparam logic [31:0] DMEM_BYTES = 32'h0000_4000;

    // Loadable window spans imem through the end of dmem.
    localparam logic [31:0] LOAD_WINDOW_BYTES = DMEM_BASE + DMEM_BYTES - IMEM_BASE;

    // 33-bit compare so a window touching the top of the address space cannot wrap.
    function automatic logic addr_in_window(
        input logic [31:0] addr,
        input logic [31:0] base,
        input logic [31:0] window
    );
        logic [32:0] addr_ext;
        logic [32:0] lo_ext;
        logic [32:0] hi_ext;
        addr_ext = {1'b0, addr};
        lo_ext   = {1'b0, base};
        hi_ext   = lo_ext + {1'b0, window} - 33'd4;
        return (addr_ext >= lo_ext) && (addr_ext <= hi_ext);
    endfunction

endpackage

// File: rtl/spi_prog_loader.sv
// Decodes SPI command bytes into address loads and 32-bit memory writes
// used to program imem/dmem while the core is held in reset.
module spi_prog_loader #(
    parameter logic [31:0] BASE_ADDR    = spi_prog_pkg::IMEM_BASE,
    parameter logic [31:0] WINDOW_BYTES = spi_prog_pkg::LOAD_WINDOW_BYTES,
    parameter logic [7:0]  CMD_ADDR     = spi_prog_pkg::CMD_ADDR,
    parameter logic [7:0]  CMD_DATA     = spi_prog_pkg::CMD_DATA
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        frame_abort,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    input  logic        mem_ready,
    output logic        busy,
    output logic [15:0] word_count,
    output logic        err_range,
    output logic        err_align,
    output logic        err_overrun
);
    import spi_prog_pkg::*;

    prog_state_t state_r;
    prog_state_t next_state_s;

    logic [1:0]  byte_cnt_r;
    logic [31:0] shift_sr_r;
    logic [31:0] addr_r;
    logic [31:0] mem_addr_r;
    logic [31:0] mem_wdata_r;
    logic        mem_we_r;
    logic        busy_r;
    logic [15:0] word_count_r;
    logic        err_range_r;
    logic        err_align_r;
    logic        err_overrun_r;

    logic [31:0] assembled_s;
    logic        byte_in_s;
    logic        last_byte_s;
    logic        addr_ok_s;
    logic        align_ok_s;

    logic        clear_cnt_s;
    logic        shift_en_s;
    logic        load_addr_s;
    logic        launch_write_s;
    logic        range_err_s;
    logic        align_err_s;
    logic        overrun_s;
    logic        complete_s;

    // Abort has priority: a byte arriving with frame_abort is never consumed.
    assign byte_in_s   = rx_valid && !frame_abort;
    assign last_byte_s = byte_in_s && (byte_cnt_r == 2'd3);
    assign assembled_s = {shift_sr_r[23:0], rx_data};
    assign addr_ok_s   = addr_in_window(addr_r, BASE_ADDR, WINDOW_BYTES);
    assign align_ok_s  = (addr_r[1:0] == 2'b00);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (byte_in_s && (rx_data == CMD_ADDR)) begin
                    next_state_s = ADDR;
                end else if (byte_in_s && (rx_data == CMD_DATA)) begin
                    next_state_s = DATA;
                end else begin
                    next_state_s = IDLE;
                end
            end
            ADDR: begin
                if (frame_abort || last_byte_s) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = ADDR;
                end
            end
            DATA: begin
                if (frame_abort) begin
                    next_state_s = IDLE;
                end else if (last_byte_s) begin
                    if (addr_ok_s && align_ok_s) begin
                        next_state_s = WRITE;
                    end else begin
                        next_state_s = IDLE;
                    end
                end else begin
                    next_state_s = DATA;
                end
            end
            WRITE: begin
                if (mem_ready) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = WRITE;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // Per-state datapath strobes.
    always_comb begin
        clear_cnt_s    = 1'b0;
        shift_en_s     = 1'b0;
        load_addr_s    = 1'b0;
        launch_write_s = 1'b0;
        range_err_s    = 1'b0;
        align_err_s    = 1'b0;
        overrun_s      = 1'b0;
        complete_s     = 1'b0;
        case (state_r)
            IDLE: begin
                clear_cnt_s = 1'b1;
            end
            ADDR: begin
                clear_cnt_s = frame_abort;
                shift_en_s  = byte_in_s;
                load_addr_s = last_byte_s;
            end
            DATA: begin
                clear_cnt_s    = frame_abort;
                shift_en_s     = byte_in_s;
                launch_write_s = last_byte_s && addr_ok_s && align_ok_s;
                range_err_s    = last_byte_s && !addr_ok_s;
                align_err_s    = last_byte_s && !align_ok_s;
            end
            WRITE: begin
                overrun_s  = rx_valid;
                complete_s = mem_ready;
            end
            default: begin
                clear_cnt_s = 1'b1;
            end
        endcase
    end

    // Byte counter and the 4-byte shift assembler shared by address and data.
    always_ff @(posedge clk) begin
        if (reset) begin
            byte_cnt_r <= 2'd0;
            shift_sr_r <= 32'd0;
        end else begin
            if (clear_cnt_s) begin
                byte_cnt_r <= 2'd0;
            end else if (shift_en_s) begin
                byte_cnt_r <= byte_cnt_r + 2'd1;
            end
            if (shift_en_s) begin
                shift_sr_r <= assembled_s;
            end
        end
    end

    // Target address: loaded by the address command, stepped after each commit.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_r <= BASE_ADDR;
        end else if (load_addr_s) begin
            addr_r <= assembled_s;
        end else if (complete_s) begin
            addr_r <= addr_r + 32'd4;
        end
    end

    // Memory write port; address and data stay frozen until the handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_we_r    <= 1'b0;
            mem_addr_r  <= 32'd0;
            mem_wdata_r <= 32'd0;
        end else if (launch_write_s) begin
            mem_we_r    <= 1'b1;
            mem_addr_r  <= addr_r;
            mem_wdata_r <= assembled_s;
        end else if (complete_s) begin
            mem_we_r    <= 1'b0;
        end
    end

    // Status: busy, saturating write count and sticky error flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_r        <= 1'b0;
            word_count_r  <= 16'd0;
            err_range_r   <= 1'b0;
            err_align_r   <= 1'b0;
            err_overrun_r <= 1'b0;
        end else begin
            busy_r <= (next_state_s != IDLE);
            if (complete_s && (word_count_r != 16'hFFFF)) begin
                word_count_r <= word_count_r + 16'd1;
            end
            if (range_err_s) begin
                err_range_r <= 1'b1;
            end
            if (align_err_s) begin
                err_align_r <= 1'b1;
            end
            if (overrun_s) begin
                err_overrun_r <= 1'b1;
            end
        end
    end

    assign mem_addr    = mem_addr_r;
    assign mem_wdata   = mem_wdata_r;
    assign mem_we      = mem_we_r;
    assign busy        = busy_r;
    assign word_count  = word_count_r;
    assign err_range   = err_range_r;
    assign err_align   = err_align_r;
    assign err_overrun = err_overrun_r;

endmodule

// File: tb/tb_spi_prog_loader.sv
// Directed bench for spi_prog_loader: byte-level command sequences with
// hand-computed write addresses, data, counts and error flags.
module tb_spi_prog_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        frame_abort;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic        mem_ready;
    logic        busy;
    logic [15:0] word_count;
    logic        err_range;
    logic        err_align;
    logic        err_overrun;

    int n_vec  = 0;
    int n_miss = 0;

    logic [31:0] log_addr [0:15];
    logic [31:0] log_data [0:15];
    int          n_log = 0;

    always #5 clk = ~clk;

    spi_prog_loader dut (
        .clk         (clk),
        .reset       (reset),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .frame_abort (frame_abort),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_we      (mem_we),
        .mem_ready   (mem_ready),
        .busy        (busy),
        .word_count  (word_count),
        .err_range   (err_range),
        .err_align   (err_align),
        .err_overrun (err_overrun)
    );

    // Record every accepted write; inputs change at posedge+2 so negedge is stable.
    always @(negedge clk) begin
        if (mem_we && mem_ready && (n_log < 16)) begin
            log_addr[n_log] <= mem_addr;
            log_data[n_log] <= mem_wdata;
            n_log           <= n_log + 1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk);
        #2;
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #2;
        rx_valid = 1'b0;
    endtask

    task automatic send_cmd(input logic [7:0] op, input logic [31:0] word);
        send_byte(op);
        send_byte(word[31:24]);
        send_byte(word[23:16]);
        send_byte(word[15:8]);
        send_byte(word[7:0]);
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!busy) return;
        end
        check_eq(tag, {31'd0, busy}, 32'd0);
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_addr"}, mem_addr, 32'd0);
        check_eq({tag, "_wdata"}, mem_wdata, 32'd0);
        check_eq({tag, "_we"}, {31'd0, mem_we}, 32'd0);
        check_eq({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check_eq({tag, "_wcnt"}, {16'd0, word_count}, 32'd0);
        check_eq({tag, "_errs"}, {29'd0, err_range, err_align, err_overrun}, 32'd0);
    endtask

    initial begin
        reset       = 1'b1;
        rx_data     = 8'h00;
        rx_valid    = 1'b0;
        frame_abort = 1'b0;
        mem_ready   = 1'b1;
        tick(3);
        reset = 1'b0;
        tick(1);
        check_reset_state("rst");

        // Basic write at the base address.
        send_cmd(8'h01, 32'h1000_0000);
        check_eq("addr_cmd_idle", {31'd0, busy}, 32'd0);
        send_cmd(8'h02, 32'hDEAD_BEEF);
        check_eq("lat_we", {31'd0, mem_we}, 32'd1);
        wait_idle("wr0_timeout");
        check_eq("wr0_nlog", n_log, 32'd1);
        check_eq("wr0_addr", log_addr[0], 32'h1000_0000);
        check_eq("wr0_data", log_data[0], 32'hDEAD_BEEF);
        check_eq("wr0_wcnt", {16'd0, word_count}, 32'd1);
        check_eq("wr0_errs", {29'd0, err_range, err_align, err_overrun}, 32'd0);

        // Auto-increment across two data commands.
        send_cmd(8'h01, 32'h1000_4000);
        send_cmd(8'h02, 32'h1122_3344);
        wait_idle("wr1_timeout");
        send_cmd(8'h02, 32'h5566_7788);
        wait_idle("wr2_timeout");
        check_eq("inc_nlog", n_log, 32'd3);
        check_eq("inc_addr1", log_addr[1], 32'h1000_4000);
        check_eq("inc_data1", log_data[1], 32'h1122_3344);
        check_eq("inc_addr2", log_addr[2], 32'h1000_4004);
        check_eq("inc_data2", log_data[2], 32'h5566_7788);
        check_eq("inc_wcnt", {16'd0, word_count}, 32'd3);

        // Top of window is writable; the next increment falls outside.
        send_cmd(8'h01, 32'h1000_7FFC);
        send_cmd(8'h02, 32'hCAFE_0001);
        wait_idle("top_timeout");
        check_eq("top_addr", log_addr[3], 32'h1000_7FFC);
        check_eq("top_errs", {30'd0, err_range, err_align}, 32'd0);
        send_cmd(8'h02, 32'h0BAD_0002);
        check_eq("oob_we", {31'd0, mem_we}, 32'd0);
        tick(2);
        check_eq("oob_nlog", n_log, 32'd4);
        check_eq("oob_range", {31'd0, err_range}, 32'd1);
        check_eq("oob_align", {31'd0, err_align}, 32'd0);

        // Misaligned address is dropped.
        send_cmd(8'h01, 32'h1000_0002);
        send_cmd(8'h02, 32'h0000_0001);
        check_eq("mis_we", {31'd0, mem_we}, 32'd0);
        tick(2);
        check_eq("mis_nlog", n_log, 32'd4);
        check_eq("mis_align", {31'd0, err_align}, 32'd1);
        check_eq("mis_wcnt", {16'd0, word_count}, 32'd4);

        // Stalled write with an overrun byte in the middle.
        mem_ready = 1'b0;
        send_cmd(8'h01, 32'h1000_0100);
        send_cmd(8'h02, 32'hA5A5_A5A5);
        check_eq("stall_we0", {31'd0, mem_we}, 32'd1);
        tick(3);
        send_byte(8'h01);
        tick(4);
        check_eq("stall_we", {31'd0, mem_we}, 32'd1);
        check_eq("stall_addr", mem_addr, 32'h1000_0100);
        check_eq("stall_data", mem_wdata, 32'hA5A5_A5A5);
        check_eq("stall_ovr", {31'd0, err_overrun}, 32'd1);
        check_eq("stall_nlog", n_log, 32'd4);
        mem_ready = 1'b1;
        wait_idle("stall_timeout");
        tick(2);
        check_eq("stall_idle", {31'd0, busy}, 32'd0);
        check_eq("stall_waddr", log_addr[4], 32'h1000_0100);
        check_eq("stall_wcnt", {16'd0, word_count}, 32'd5);

        // Abort of a partial address, plus abort colliding with a byte.
        send_cmd(8'h01, 32'h1000_0000);
        send_byte(8'h01);
        send_byte(8'h10);
        send_byte(8'h00);
        @(posedge clk);
        #2;
        frame_abort = 1'b1;
        rx_valid    = 1'b1;
        rx_data     = 8'h02;
        @(posedge clk);
        #2;
        frame_abort = 1'b0;
        rx_valid    = 1'b0;
        tick(1);
        check_eq("abort_idle", {31'd0, busy}, 32'd0);
        send_cmd(8'h02, 32'hCAFE_BABE);
        check_eq("abort_maddr", mem_addr, 32'h1000_0000);
        wait_idle("abort_timeout");
        check_eq("abort_addr", log_addr[5], 32'h1000_0000);
        check_eq("abort_data", log_data[5], 32'hCAFE_BABE);

        // Reset in the middle of a data command.
        send_byte(8'h02);
        send_byte(8'h11);
        send_byte(8'h22);
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(1);
        check_reset_state("midrst");
        check_eq("midrst_nlog", n_log, 32'd6);
        send_cmd(8'h02, 32'h3344_5566);
        check_eq("post_maddr", mem_addr, 32'h1000_0000);
        wait_idle("post_timeout");
        check_eq("post_data", log_data[6], 32'h3344_5566);
        check_eq("post_wcnt", {16'd0, word_count}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
